// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback control
// with a bounded memory wait that traps on timeout, plus a retired-instruction counter.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        busy,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // The wait counter holds the number of missed cycles already seen, so the
  // access traps on the cycle that would make it reach MEM_TIMEOUT.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] wait_inc(input logic [3:0] w);
    wait_inc = (w == 4'hF) ? w : w + 4'd1;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [3:0]  wait_q, wait_d;
  logic        retire;
  logic        is_load, is_store, is_branch;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wait_d    = wait_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_inc(wait_q);
        end
      end
      S_DECODE: begin
        state_d = op_legal(opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (is_branch) begin
          retire = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) retire = 1'b1;
          else          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_inc(wait_q);
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase

    if (retire) begin
      pc_write = 1'b1;
      count_d  = count_q + 16'd1;
      wait_d   = '0;
      state_d  = halt_req ? S_HALT : S_FETCH;
    end

    // Reset aborts whatever is in flight, so no strobe may escape in that cycle.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

  assign state       = state_q;
  assign busy        = (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB});
  assign instr_count = count_q;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, is the maximum number of cycles a memory access waits for mem_ready before trapping (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  level; leave IDLE and begin fetching.
REQ-005 halt_req  input  1  level; stop at the next instruction boundary.
REQ-006 opcode  input  7  instruction[6:0] from the instruction register, valid from DECODE onward.
REQ-007 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-008 state  output  3  current state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
REQ-009 mem_req  output  1  memory access request; high throughout FETCH and for loads/stores in MEM.
REQ-010 mem_we  output  1  write qualifier for mem_req; high only in MEM for a store.
REQ-011 ir_write  output  1  one-cycle pulse loading the instruction register.
REQ-012 pc_write  output  1  one-cycle pulse enabling the program-counter update.
REQ-013 reg_write  output  1  one-cycle register-file write enable.
REQ-014 busy  output  1  high in FETCH, DECODE, EXEC, MEM and WB.
REQ-015 instr_count  output  16  count of retired instructions.

Function
REQ-016 Supported opcodes: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111, LUI=0110111; any other opcode is illegal.
REQ-017 IDLE: go to FETCH when start=1, otherwise stay in IDLE.
REQ-018 FETCH: mem_req=1, mem_we=0; when mem_ready=1, pulse ir_write that same cycle and go to DECODE.
REQ-019 DECODE: one cycle; illegal opcode goes to TRAP, otherwise go to EXEC.
REQ-020 EXEC: one cycle.
- LOAD and STORE go to MEM.
- BRANCH retires here.
- All other opcodes go to WB.
REQ-021 MEM: mem_req=1, mem_we=1 for STORE; when mem_ready=1, STORE retires and LOAD goes to WB.
REQ-022 WB: one cycle; reg_write=1, then the instruction retires.
REQ-023 Retire cycle (EXEC for BRANCH, MEM for STORE, WB otherwise):
- pulse pc_write.
- increment instr_count.
- next state is HALT if halt_req=1 in that cycle, else FETCH.
REQ-024 Minimum latency, counting from entering FETCH with mem_ready already high:
- BRANCH: 3 cycles.
- R, I, JAL, JALR, LUI: 4 cycles.
- STORE: 4 cycles.
- LOAD: 5 cycles.
REQ-025 A 4-bit wait counter clears on entering FETCH or MEM and increments each cycle mem_ready=0; when it reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP next cycle and deassert mem_req.
REQ-026 mem_ready sampled high on the timeout cycle wins: the access completes and no trap occurs.
REQ-027 mem_ready outside FETCH and MEM is ignored.
REQ-028 HALT and TRAP are sticky; only reset leaves them, and start is ignored in both.
REQ-029 halt_req has no effect outside the retire cycle and IDLE; halt_req=1 in IDLE goes to HALT, taking priority over start.
REQ-030 instr_count wraps 16'hFFFF -> 16'h0000 without flagging.
REQ-031 Outputs ir_write, pc_write, reg_write, mem_req and mem_we are decoded from the current state plus inputs only; they are never high in IDLE, HALT or TRAP.

Reset
REQ-032 On reset=1:
- next state is IDLE.
- instr_count=0 and wait counter=0.
- all pulse outputs read 0 the following cycle.
REQ-033 Reset asserted mid-instruction (any state, including MEM with mem_req high) aborts the instruction with no pc_write or reg_write pulse; reset takes priority over all inputs.

Verification
REQ-034 Reset, start=1, mem_ready=1 constant, opcode=0110011 -> state sequence 1,2,3,5,1; pc_write and reg_write high in WB; instr_count=1 after the first retire.
REQ-035 LOAD (0000011) with mem_ready low for 3 MEM cycles -> mem_req held for 4 MEM cycles, then WB with reg_write=1; 8 cycles total from FETCH entry.
REQ-036 FETCH with mem_ready held 0 -> state=7 on cycle 16 after FETCH entry (MEM_TIMEOUT=15); mem_req=0 from then on; start and mem_ready are ignored until reset.
REQ-037 opcode=1111111 at DECODE -> TRAP, with no pc_write and instr_count unchanged.
REQ-038 BRANCH retire with halt_req=1 -> pc_write pulse, state=6 next cycle, busy=0; a later start=1 leaves the state at 6.
REQ-039 Preload instr_count to 16'hFFFF via 65535 retires, then one more retire -> instr_count=0; reset asserted during MEM of a STORE -> state=0 next cycle, no pc_write.
